// File: rtl/msrr_sequencer.sv
// Sequencer and two-port arbiter for the 8-bit multi-mode shift/rotate register.
// Define MSRR_SEQ_FIXED_PRIO_EN for fixed priority (req[0] wins); round-robin otherwise.
module msrr_sequencer (
    input  logic       clk,
    input  logic       Re,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [2:0] rot0,
    input  logic [2:0] rot1,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [1:0] sr_mode,
    output logic       sr_sIn,
    output logic       sr_inz,
    input  logic [7:0] sr_Q
);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, ROT, DONE} state_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHL   = 2'b01;
    localparam logic [1:0] MODE_ROTR  = 2'b11;

    state_t     state;
    logic [7:0] data_q;
    logic [2:0] rot_q;
    logic [2:0] k;
    logic [2:0] rcnt;
    logic       win;

`ifdef MSRR_SEQ_FIXED_PRIO_EN
    assign win = ~req[0];
`else
    logic last_ptr;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        if (req == 2'b11) win = ~last_ptr;
        else              win = req[1];
    end
`endif

    always_ff @(posedge clk) begin
        if (!Re) begin
            state   <= IDLE;
            grant   <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 8'h00;
            sr_mode <= MODE_HOLD;
            sr_sIn  <= 1'b0;
            sr_inz  <= 1'b0;
            data_q  <= 8'h00;
            rot_q   <= 3'd0;
            k       <= 3'd0;
            rcnt    <= 3'd0;
`ifndef MSRR_SEQ_FIXED_PRIO_EN
            last_ptr <= 1'b1;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sr_mode <= MODE_HOLD;
                    sr_sIn  <= 1'b0;
                    sr_inz  <= 1'b0;
                    if (req != 2'b00) begin
                        grant  <= win ? 2'b10 : 2'b01;
                        data_q <= win ? data1 : data0;
                        rot_q  <= win ? rot1 : rot0;
                        busy   <= 1'b1;
                        sr_inz <= 1'b1;
                        state  <= CLEAR;
`ifndef MSRR_SEQ_FIXED_PRIO_EN
                        last_ptr <= win;
`endif
                    end
                end
                CLEAR: begin
                    // Outputs are registered, so the first LOAD bit is presented here.
                    sr_inz  <= 1'b0;
                    sr_mode <= MODE_SHL;
                    sr_sIn  <= data_q[7];
                    k       <= 3'd7;
                    state   <= LOAD;
                end
                LOAD: begin
                    if (k == 3'd0) begin
                        sr_sIn <= 1'b0;
                        if (rot_q != 3'd0) begin
                            sr_mode <= MODE_ROTR;
                            rcnt    <= rot_q;
                            state   <= ROT;
                        end else begin
                            sr_mode <= MODE_HOLD;
                            state   <= DONE;
                        end
                    end else begin
                        k      <= k - 3'd1;
                        sr_sIn <= data_q[k - 3'd1];
                    end
                end
                ROT: begin
                    if (rcnt == 3'd1) begin
                        sr_mode <= MODE_HOLD;
                        state   <= DONE;
                    end else begin
                        rcnt <= rcnt - 3'd1;
                    end
                end
                DONE: begin
                    result <= sr_Q;
                    done   <= 1'b1;
                    grant  <= 2'b00;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                    sr_mode <= MODE_HOLD;
                    sr_sIn  <= 1'b0;
                    sr_inz  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msrr_sequencer.sv
// Self-checking bench for msrr_sequencer: a transaction-level model plus directed scenarios.
// Also honours MSRR_SEQ_FIXED_PRIO_EN for the tie-break expectations.
module tb_msrr_sequencer;

    logic       clk = 1'b0;
    logic       Re;
    logic [1:0] req;
    logic [7:0] data0, data1;
    logic [2:0] rot0, rot1;
    logic [1:0] grant;
    logic       busy, done;
    logic [7:0] result;
    logic [1:0] sr_mode;
    logic       sr_sIn, sr_inz;
    logic [7:0] sr_Q = 8'h00;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    msrr_sequencer dut (
        .clk(clk), .Re(Re), .req(req), .data0(data0), .data1(data1),
        .rot0(rot0), .rot1(rot1), .grant(grant), .busy(busy), .done(done),
        .result(result), .sr_mode(sr_mode), .sr_sIn(sr_sIn), .sr_inz(sr_inz),
        .sr_Q(sr_Q)
    );

    always #5 clk = ~clk;

    // The shift/rotate register the sequencer drives.
    always @(posedge clk) begin
        if (sr_inz) sr_Q <= 8'h00;
        else begin
            case (sr_mode)
                2'b01:   sr_Q <= {sr_Q[6:0], sr_sIn};
                2'b10:   sr_Q <= {1'b0, sr_Q[7:1]};
                2'b11:   sr_Q <= {sr_Q[0], sr_Q[7:1]};
                default: sr_Q <= sr_Q;
            endcase
        end
    end

    function automatic logic [7:0] rotr(input logic [7:0] d, input int r);
        logic [15:0] t;
        t = {d, d} >> r;
        return t[7:0];
    endfunction

    // Transaction model: m_p counts edges since the granting edge.
    bit         m_active = 1'b0;
    int         m_p = 0;
    bit         m_win = 1'b0;
    bit         m_last = 1'b1;
    logic [7:0] m_data = 8'h00;
    int         m_rot = 0;
    logic [7:0] m_result = 8'h00;
    bit         m_done = 1'b0;

    always @(posedge clk) begin
        if (!Re) begin
            m_active = 1'b0; m_last = 1'b1; m_result = 8'h00; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_p++;
                if (m_p == 11 + m_rot) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                    m_result = rotr(m_data, m_rot);
                end
            end else if (req != 2'b00) begin
                if (req == 2'b01) m_win = 1'b0;
                else if (req == 2'b10) m_win = 1'b1;
`ifdef MSRR_SEQ_FIXED_PRIO_EN
                else m_win = 1'b0;
`else
                else m_win = (m_last == 1'b1) ? 1'b0 : 1'b1;
`endif
                m_last = m_win;
                m_data = m_win ? data1 : data0;
                m_rot = m_win ? int'(rot1) : int'(rot0);
                m_active = 1'b1;
                m_p = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] q, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [2:0] r0, input logic [2:0] r1);
        req = q; data0 = d0; data1 = d1; rot0 = r0; rot1 = r1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            logic [1:0] eg, em;
            logic es, ei;
            eg = 2'b00; em = 2'b00; es = 1'b0; ei = 1'b0;
            if (m_active) begin
                eg = m_win ? 2'b10 : 2'b01;
                ei = (m_p == 1);
                if (m_p >= 2 && m_p <= 9) begin
                    em = 2'b01;
                    es = m_data[9 - m_p];
                end else if (m_p >= 10 && m_p <= 9 + m_rot) em = 2'b11;
            end
            checkOutput("grant", 32'(grant), 32'(eg));
            checkOutput("busy", 32'(busy), 32'(m_active));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("result", 32'(result), 32'(m_result));
            checkOutput("sr_mode", 32'(sr_mode), 32'(em));
            checkOutput("sr_sIn", 32'(sr_sIn), 32'(es));
            checkOutput("sr_inz", 32'(sr_inz), 32'(ei));
        end
    end

    // Waits for done, counting cycles by category along the way.
    task automatic waitDone(input int maxCycles, output int lat, output int gntCyc, output int inzCyc,
                            output int loadOnes, output int rotCyc, output logic [1:0] firstGnt);
        lat = 0; gntCyc = 0; inzCyc = 0; loadOnes = 0; rotCyc = 0; firstGnt = 2'b00;
        while (1) begin
            @(negedge clk);
            lat++;
            if (firstGnt == 2'b00 && grant != 2'b00) firstGnt = grant;
            if (grant != 2'b00 && grant == firstGnt) gntCyc++;
            if (sr_inz) inzCyc++;
            if (sr_mode == 2'b01 && sr_sIn) loadOnes++;
            if (sr_mode == 2'b11) rotCyc++;
            if (done) break;
            if (lat >= maxCycles) begin
                checkOutput("done_timeout", 32'(lat), 32'(maxCycles + 1));
                break;
            end
        end
    endtask

    initial begin
        int lat, gc, ic, lo, rc;
        logic [1:0] fg;
        logic [1:0] tieGnt [3];

        Re = 1'b0;
        applyStimulus(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);
        repeat (3) @(negedge clk);
        cmpEn = 1'b1;
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_result", 32'(result), 32'h0);
        checkOutput("rst_mode", 32'(sr_mode), 32'h0);
        Re = 1'b1;
        @(negedge clk);

        // Basic load, no rotate.
        applyStimulus(2'b01, 8'hA5, 8'h00, 3'd0, 3'd0);
        waitDone(40, lat, gc, ic, lo, rc, fg);
        checkOutput("t1_lat", 32'(lat), 32'd11);
        checkOutput("t1_grant_cycles", 32'(gc), 32'd10);
        checkOutput("t1_inz_cycles", 32'(ic), 32'd1);
        checkOutput("t1_result", 32'(result), 32'hA5);
        applyStimulus(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);
        @(negedge clk);

        // Requester 1 with rotates.
        applyStimulus(2'b10, 8'h00, 8'hA5, 3'd0, 3'd1);
        waitDone(40, lat, gc, ic, lo, rc, fg);
        checkOutput("t2_lat", 32'(lat), 32'd12);
        checkOutput("t2_grant", 32'(fg), 32'h2);
        checkOutput("t2_result", 32'(result), 32'hD2);
        applyStimulus(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);
        @(negedge clk);
        applyStimulus(2'b10, 8'h00, 8'h3C, 3'd0, 3'd4);
        waitDone(40, lat, gc, ic, lo, rc, fg);
        checkOutput("t3_lat", 32'(lat), 32'd15);
        checkOutput("t3_result", 32'(result), 32'hC3);
        applyStimulus(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);
        @(negedge clk);

        // Both requesting continuously: back-to-back grants.
        applyStimulus(2'b11, 8'h11, 8'h22, 3'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            waitDone(40, lat, gc, ic, lo, rc, fg);
            tieGnt[i] = fg;
            checkOutput("tie_lat", 32'(lat), 32'd11);
        end
        applyStimulus(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);
        checkOutput("tie_g0", 32'(tieGnt[0]), 32'h1);
`ifdef MSRR_SEQ_FIXED_PRIO_EN
        checkOutput("tie_g1", 32'(tieGnt[1]), 32'h1);
`else
        checkOutput("tie_g1", 32'(tieGnt[1]), 32'h2);
`endif
        checkOutput("tie_g2", 32'(tieGnt[2]), 32'h1);
        @(negedge clk);

        // Reset in the middle of LOAD.
        applyStimulus(2'b01, 8'h5A, 8'h00, 3'd3, 3'd0);
        repeat (4) @(negedge clk);
        Re = 1'b0;
        applyStimulus(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);
        @(negedge clk);
        checkOutput("mid_rst_grant", 32'(grant), 32'h0);
        checkOutput("mid_rst_busy", 32'(busy), 32'h0);
        checkOutput("mid_rst_done", 32'(done), 32'h0);
        checkOutput("mid_rst_mode", 32'(sr_mode), 32'h0);
        checkOutput("mid_rst_result", 32'(result), 32'h0);
        Re = 1'b1;
        @(negedge clk);

        // All-ones word with the maximum rotate.
        applyStimulus(2'b01, 8'hFF, 8'h00, 3'd7, 3'd0);
        waitDone(40, lat, gc, ic, lo, rc, fg);
        checkOutput("t5_lat", 32'(lat), 32'd18);
        checkOutput("t5_load_ones", 32'(lo), 32'd8);
        checkOutput("t5_rot_cycles", 32'(rc), 32'd7);
        checkOutput("t5_result", 32'(result), 32'hFF);
        applyStimulus(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);
        @(negedge clk);

        // Changing data0 after grant must not matter.
        applyStimulus(2'b01, 8'h96, 8'h00, 3'd2, 3'd0);
        repeat (4) @(negedge clk);
        data0 = 8'h00;
        rot0 = 3'd5;
        waitDone(40, lat, gc, ic, lo, rc, fg);
        checkOutput("t6_result", 32'(result), 32'hA5);
        applyStimulus(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/msrr_sequencer.md
# msrr_sequencer

Sequencer and two-port arbiter for the 8-bit multi-mode shift/rotate register. Two requesters each present an 8-bit word and a rotate amount. The block grants one requester and clears the register. It then loads the word serially, MSB first, and rotates the result right by the requested amount. Finally it returns the register contents with a one-cycle done pulse. It sits between client logic and the register, and is the only driver of the register's mode, serial-in and clear inputs.

## Interface
Parameters:
- none; width is fixed at 8 bits and rotate amount at 3 bits.

Ports:
- clk  in  1  clock; every flop updates on the rising edge.
- Re  in  1  synchronous, active-low reset.
- req  in  2  requests; bit i belongs to requester i. Each requester holds its bit until it sees its done.
- data0, data1  in  8  words to load; captured at grant.
- rot0, rot1  in  3  rotate-right amounts, 0..7; captured at grant.
- grant  out  2  one-hot while busy, 2'b00 when idle.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  8  register contents captured at the end of the transaction; held until the next capture.
- sr_mode  out  2  drives the register's mode input:
  - 00 = hold
  - 01 = shift left, sIn enters the LSB
  - 10 = shift right
  - 11 = rotate right
- sr_sIn  out  1  register serial input.
- sr_inz  out  1  register clear; the register becomes 0x00 on the next edge.
- sr_Q  in  8  register parallel output.

## Operation
- The state machine has five states: IDLE, CLEAR, LOAD, ROT, DONE.
- IDLE
  - sr_mode=00, sr_inz=0.
  - If req is non-zero: arbitrate, latch the winner's data and rot, set grant, go to CLEAR.
- CLEAR (1 cycle)
  - sr_inz=1, sr_mode=00.
  - Bit counter k is set to 7.
- LOAD (8 cycles)
  - sr_mode=01, sr_sIn=data[k].
  - k decrements each cycle.
  - After the k=0 cycle: go to ROT if rot≠0, otherwise DONE.
- ROT (rot cycles)
  - sr_mode=11.
  - A rotate counter counts down from rot; the state exits to DONE when it reaches 1.
- DONE (1 cycle)
  - sr_mode=00.
  - On the exit edge: result←sr_Q, done←1, grant←00, go to IDLE.
- done is registered: it is high during the first IDLE cycle after DONE.
- Arbitration is round-robin via a last-grant pointer.
  - Only one request pending: that requester wins.
  - Both pending: the requester not granted last wins.
  - The pointer updates on every grant.
- sr_sIn=0 in every state except LOAD.
- Changes on req, data or rot while busy are ignored.
- A requester that drops req before grant is never granted.

## Timing
- Let E0 be the edge on which IDLE samples a non-zero req.
  - The register clears on E1.
  - Shifts occur on E2..E9.
  - Rotates occur on E10..E9+r.
  - DONE occupies the cycle after E9+r.
  - done and the new result appear after E10+r.
- Total latency from E0 to done is 10+r edges: 10 to 17 cycles.
- Back-to-back transactions are allowed. The IDLE cycle that carries done may also sample req, so consecutive grants are 11+r edges apart.
- Reset: while Re=0 at an edge, the block returns to the reset state, including mid-transaction. No partial result is published.

| Signal | Reset value |
|---|---|
| state | IDLE |
| grant | 00 |
| busy | 0 |
| done | 0 |
| result | 0x00 |
| sr_mode | 00 |
| sr_sIn | 0 |
| sr_inz | 0 |
| last-grant pointer | 1 (requester 0 wins the first tie) |

## Configuration
- MSRR_SEQ_FIXED_PRIO_EN
  - Defined: fixed priority; req[0] always beats req[1], and the last-grant pointer is not implemented.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Reset, then req=01, data0=0xA5, rot0=0 → grant=01 for 10 cycles; done after E10 with result=0xA5; sr_inz high exactly one cycle.
- req=10, data1=0xA5, rot1=1 → done after E11, result=0xD2. Then data1=0x3C, rot1=4 → result=0xC3 after 14 edges.
- req=11 held continuously, rot0=rot1=0 → grants alternate 01, 10, 01 at 11-edge spacing. With MSRR_SEQ_FIXED_PRIO_EN defined, grant stays 01.
- Re=0 for one edge during LOAD → the next cycle shows IDLE, grant=00, busy=0, done=0, sr_mode=00, and result unchanged at 0x00.
- data0=0xFF, rot0=7 → each LOAD cycle shows sr_mode=01 and sr_sIn=1; 7 ROT cycles show sr_mode=11; result=0xFF after E17.
- Change data0 during LOAD → no effect on sr_sIn or result.
